// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control path.
// Contents:
//   - pc_source mux select values (PCSRC_*)
//   - request kinds issued by main control (req_kind_e)
//   - exception causes (exc_code_e)
//   - default handler-vector byte addresses (VEC_*_DEF)
package cpu_ctrl_pkg;

  localparam logic [2:0] PCSRC_JUMP   = 3'b000;
  localparam logic [2:0] PCSRC_ALU    = 3'b001;
  localparam logic [2:0] PCSRC_EPC    = 3'b010;
  localparam logic [2:0] PCSRC_ALUOUT = 3'b011;
  localparam logic [2:0] PCSRC_MEMVEC = 3'b100;

  typedef enum logic [2:0] {
    REQ_SEQ    = 3'd0,
    REQ_JUMP   = 3'd1,
    REQ_JR     = 3'd2,
    REQ_BRANCH = 3'd3,
    REQ_RTE    = 3'd4,
    REQ_EXC    = 3'd5
  } req_kind_e;

  typedef enum logic [1:0] {
    EXC_OPCODE = 2'd0,
    EXC_OVF    = 2'd1,
    EXC_DIV0   = 2'd2
  } exc_code_e;

  localparam logic [31:0] VEC_OPCODE_DEF = 32'd254;
  localparam logic [31:0] VEC_OVF_DEF    = 32'd255;
  localparam logic [31:0] VEC_DIV0_DEF   = 32'd253;

endpackage

// File: rtl/exc_vec_lookup.sv
// Combinational map from exception cause to handler-vector byte address.
// Ports:
//   exc_code  in  2   exception cause
//   vec_addr  out 32  byte address of the handler vector (0 when illegal)
//   illegal   out 1   cause code has no handler
module exc_vec_lookup
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_DEF,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_DEF,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DEF
) (
  input  logic [1:0]  exc_code,
  output logic [31:0] vec_addr,
  output logic        illegal
);

  always_comb begin
    vec_addr = '0;
    illegal  = 1'b0;
    case (exc_code)
      EXC_OPCODE: vec_addr = VEC_OPCODE;
      EXC_OVF:    vec_addr = VEC_OVF;
      EXC_DIV0:   vec_addr = VEC_DIV0;
      default:    illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC redirect sequencer. Takes one PC-update request per instruction
// phase from main control, drives the next-PC mux select and the PC/EPC
// load enables, and runs the multi-cycle exception entry
// (save EPC, fetch vector byte, load PC).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req_valid          request strobe
//   req_kind [2:0]     SEQ/JUMP/JR/BRANCH/RTE/EXC (6-7 illegal)
//   exc_code [1:0]     exception cause, sampled with EXC
//   cond_true          branch condition, sampled with BRANCH
//   busy               request in progress
//   done               one-cycle completion pulse
//   req_drop           one-cycle rejection pulse
//   pc_source [2:0]    next-PC mux select
//   pc_write           PC load enable
//   epc_write          EPC load enable
//   mem_read           vector-byte read strobe
//   vec_addr [31:0]    vector byte address
module pc_redirect_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_DEF,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_DEF,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_kind,
  input  logic [1:0]  exc_code,
  input  logic        cond_true,
  output logic        busy,
  output logic        done,
  output logic        req_drop,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic        epc_write,
  output logic        mem_read,
  output logic [31:0] vec_addr
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    EXC_SAVE,
    EXC_WAIT,
    EXC_LOAD
  } state_e;

  state_e             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               drop_pend;
  logic [31:0]        lk_addr;
  logic               lk_illegal;
  logic               to_load;

  exc_vec_lookup #(
    .VEC_OPCODE (VEC_OPCODE),
    .VEC_OVF    (VEC_OVF),
    .VEC_DIV0   (VEC_DIV0)
  ) u_vec (
    .exc_code (exc_code),
    .vec_addr (lk_addr),
    .illegal  (lk_illegal)
  );

  // Exception entry moves to the PC-load cycle on this edge.
  always_comb begin
    to_load = 1'b0;
    if (state == EXC_SAVE && MEM_LAT == 1)
      to_load = 1'b1;
    else if (state == EXC_WAIT && wait_cnt == CNT_W'(1))
      to_load = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      drop_pend <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_drop  <= 1'b0;
      pc_source <= PCSRC_ALU;
      pc_write  <= 1'b0;
      epc_write <= 1'b0;
      mem_read  <= 1'b0;
      vec_addr  <= '0;
    end else begin
      done      <= 1'b0;
      pc_write  <= 1'b0;
      epc_write <= 1'b0;
      drop_pend <= 1'b0;
      req_drop  <= drop_pend;

      // A request rejected on the edge that enters EXC_LOAD would pulse
      // req_drop together with done; it is held one cycle so the two
      // pulses never coincide.
      if (req_valid && state != IDLE) begin
        if (to_load)
          drop_pend <= 1'b1;
        else
          req_drop  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            case (req_kind)
              REQ_SEQ, REQ_JR, REQ_JUMP, REQ_RTE, REQ_BRANCH: begin
                state    <= ISSUE;
                busy     <= 1'b1;
                done     <= 1'b1;
                pc_write <= (req_kind == REQ_BRANCH) ? cond_true : 1'b1;
                case (req_kind)
                  REQ_JUMP:   pc_source <= PCSRC_JUMP;
                  REQ_RTE:    pc_source <= PCSRC_EPC;
                  REQ_BRANCH: pc_source <= PCSRC_ALUOUT;
                  default:    pc_source <= PCSRC_ALU;
                endcase
              end
              REQ_EXC: begin
                if (lk_illegal) begin
                  req_drop <= 1'b1;
                end else begin
                  state     <= EXC_SAVE;
                  busy      <= 1'b1;
                  epc_write <= 1'b1;
                  mem_read  <= 1'b1;
                  vec_addr  <= lk_addr;
                  pc_source <= PCSRC_MEMVEC;
                end
              end
              default: req_drop <= 1'b1;
            endcase
          end
        end
        ISSUE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        EXC_SAVE, EXC_WAIT: begin
          if (to_load) begin
            state    <= EXC_LOAD;
            pc_write <= 1'b1;
            done     <= 1'b1;
            mem_read <= 1'b0;
          end else if (state == EXC_SAVE) begin
            state    <= EXC_WAIT;
            wait_cnt <= CNT_W'(MEM_LAT - 1);
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        EXC_LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
